axi_sim_loop: RTL and testbench
===============================

Name: axi_sim_loop

Overview:
- Self-contained AXI4 simulation subsystem. Three stages in one chain: an active traffic-generating master, a passthrough protocol monitor, and a memory-model slave.
- After reset it writes a deterministic burst pattern into the slave memory, reads it back, compares, and reports status.
- Serves as the DUT for AXI master / passthrough / slave scoreboarding benches.

Parameters:
- ADDR_W, 12, AXI address width (byte address).
- DATA_W, 32, AXI data width; fixed at 32, full strobes.
- MEM_DEPTH, 256, slave memory depth in 32-bit words.
- NUM_TXN, 8, number of write bursts, and also number of read bursts.
- BURST_LEN, 4, beats per INCR burst (AxLEN = BURST_LEN-1, AxSIZE = 2).

Ports:
- aclk, in, 1, clock; all logic is rising-edge.
- aresetn, in, 1, reset; synchronous, active-low.
- done, out, 1, test sequence finished; sticky until reset.
- pass, out, 1, valid when done; 1 = no mismatch and no error response.
- mismatch_cnt, out, 16, count of read beats whose data differed from the expected pattern.
- wr_beats, out, 16, W handshakes counted by the passthrough monitor.
- rd_beats, out, 16, R handshakes counted by the passthrough monitor.
- resp_err_cnt, out, 16, count of BRESP or RRESP values other than OKAY.
- protocol_err, out, 1, sticky; set on a WLAST/RLAST position error.

Behaviour:
- Reset is synchronous, active-low (aresetn sampled on aclk):
  - All outputs go to 0 and all FSMs go to IDLE.
  - All VALID/READY signals go low.
  - Memory contents are not cleared.
- Auto-start: the master leaves IDLE on the 2nd rising edge after aresetn goes high.
- Transaction addressing and data:
  - Transaction i (0..NUM_TXN-1) uses address i*BURST_LEN*4.
  - Beat b of transaction i carries data 0xA500_0000 | (i<<8) | b.
- Master FSM: IDLE -> WR_AW -> WR_W -> WR_B -> (next i, or RD_AR once i = NUM_TXN) -> RD_R -> (next i, or DONE).
  - AWVALID/ARVALID stay asserted until READY; address and control are stable while VALID.
  - WVALID is continuous in WR_W; WLAST is asserted on beat BURST_LEN-1.
  - BREADY and RREADY are held high.
  - Each read beat is compared against the expected pattern; a mismatch increments mismatch_cnt.
  - Any BRESP or RRESP != OKAY increments resp_err_cnt.
  - On DONE: done=1 and pass = (mismatch_cnt==0 && resp_err_cnt==0 && !protocol_err).
- Slave write path (one outstanding transaction at a time, no reordering):
  - AWREADY asserts 1 cycle after AWVALID is seen and drops after the handshake.
  - WREADY is high in the data phase; each beat writes mem[addr>>2] and the address increments by 4.
  - BVALID is asserted the cycle after the WLAST beat, held until BREADY.
- Slave read path:
  - ARREADY has the same timing as AWREADY.
  - The first RVALID comes 1 cycle after AR acceptance; beats are back-to-back while RREADY.
  - RLAST is on the final beat.
- Out-of-range beat (word index >= MEM_DEPTH): the write is dropped and the read returns 0. The burst response is SLVERR (2'b10): on BRESP for writes, on each such beat's RRESP for reads. Otherwise OKAY.
- Passthrough monitor is wires only, zero latency, counting handshakes. It sets protocol_err when:
  - WLAST differs from (beat == AWLEN), or
  - RLAST differs from (beat == ARLEN).
- Counters saturate at 0xFFFF.
- Reset mid-operation: the FSM aborts immediately, counters clear, and the sequence restarts after reset release.
- Default run timing: done rises within 200 cycles of reset release.

Decomposition:
- Package axi_sim_pkg holds:
  - resp constants OKAY=2'b00 and SLVERR=2'b10;
  - master state enum;
  - burst type INCR=2'b01;
  - function exp_data(i, b).
- One sub-module, axi_sim_mem_slave: the slave memory and its handshakes.
- Master FSM and monitor counters live in the top module.

Test Plan:
- Hold aresetn=0 for 5 cycles -> all outputs 0, no VALID asserted.
- Default parameters, release reset -> done=1 within 200 cycles; pass=1, wr_beats=32, rd_beats=32, mismatch_cnt=0, resp_err_cnt=0, protocol_err=0.
- Pull aresetn low during WR_W of transaction 3 for 2 cycles -> outputs clear; the rerun ends with pass=1, wr_beats=32.
- MEM_DEPTH=16, NUM_TXN=8 -> transactions 4..7 are out of range: resp_err_cnt=20 (4 BRESP + 16 RRESP); read data 0 gives mismatch_cnt=16; pass=0.
- BURST_LEN=1, NUM_TXN=4 -> every beat has WLAST/RLAST=1; wr_beats=4, rd_beats=4, pass=1.
- After done, keep running 50 cycles -> done/pass stay stable and counters do not change.

Source files
------------

// File: rtl/axi_sim_pkg.sv
// Shared types and helpers for the self-checking AXI4 simulation loop:
// response/burst encodings, FSM state enums and the test data pattern.
package axi_sim_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] INCR   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW,
        ST_WR_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_DONE
    } mst_state_t;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_DATA,
        WS_RESP
    } wr_state_t;

    typedef enum logic {
        RS_IDLE,
        RS_DATA
    } rd_state_t;

    function automatic logic [31:0] exp_data(input int unsigned i, input int unsigned b);
        return 32'hA500_0000 | (i << 8) | b;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi_sim_mem_slave.sv
// AXI4 memory-model slave: one outstanding write and one outstanding read,
// INCR bursts only, SLVERR for out-of-range beats or unsupported control.
module axi_sim_mem_slave
    import axi_sim_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [ADDR_W-1:0]   i_awaddr,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_wvalid,
    output logic                o_wready,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_wlast,
    output logic                o_bvalid,
    input  logic                i_bready,
    output logic [1:0]          o_bresp,
    input  logic                i_arvalid,
    output logic                o_arready,
    input  logic [ADDR_W-1:0]   i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    output logic                o_rvalid,
    input  logic                i_rready,
    output logic [DATA_W-1:0]   o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned WA_W  = ADDR_W - 2;

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    wr_state_t       r_ws, w_ws_nxt;
    logic            r_awready, r_werr;
    logic [WA_W-1:0] r_widx;
    logic [1:0]      r_bresp;
    logic            w_aw_ok, w_aw_hs, w_w_hs, w_w_inrange;

    rd_state_t       r_rs, w_rs_nxt;
    logic            r_arready, r_rerr;
    logic [WA_W-1:0] r_ridx;
    logic [7:0]      r_rlen, r_rbeat;
    logic            w_ar_ok, w_ar_hs, w_r_hs, w_r_inrange;

    assign w_aw_ok     = (i_awburst == INCR) && (i_awsize == 3'd2) && (i_awaddr[1:0] == 2'b00);
    assign w_aw_hs     = i_awvalid && r_awready;
    assign w_w_hs      = i_wvalid && o_wready;
    assign w_w_inrange = 32'(r_widx) < MEM_DEPTH;

    assign o_awready = r_awready;
    assign o_wready  = (r_ws == WS_DATA);
    assign o_bvalid  = (r_ws == WS_RESP);
    assign o_bresp   = r_bresp;

    always_comb begin
        w_ws_nxt = r_ws;
        case (r_ws)
            WS_IDLE: if (w_aw_hs) w_ws_nxt = WS_DATA;
            WS_DATA: if (w_w_hs && i_wlast) w_ws_nxt = WS_RESP;
            WS_RESP: if (i_bready) w_ws_nxt = WS_IDLE;
            default: w_ws_nxt = WS_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_ws      <= WS_IDLE;
            r_awready <= 1'b0;
            r_widx    <= '0;
            r_werr    <= 1'b0;
            r_bresp   <= OKAY;
        end else begin
            r_ws      <= w_ws_nxt;
            r_awready <= (r_ws == WS_IDLE) && i_awvalid && !r_awready;
            if (w_aw_hs) begin
                r_widx <= i_awaddr[ADDR_W-1:2];
                r_werr <= !w_aw_ok;
            end
            if (w_w_hs) begin
                r_widx <= r_widx + WA_W'(1);
                if (!w_w_inrange) r_werr <= 1'b1;
                // BRESP folds in the current (last) beat, which r_werr has not seen yet
                if (i_wlast) r_bresp <= (r_werr || !w_w_inrange) ? SLVERR : OKAY;
            end
        end
    end

    // Memory is deliberately not reset; out-of-range beats are dropped
    always_ff @(posedge aclk) begin
        if (aresetn && w_w_hs && w_w_inrange) begin
            for (int unsigned k = 0; k < DATA_W / 8; k++) begin
                if (i_wstrb[k]) r_mem[r_widx[IDX_W-1:0]][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
    end

    assign w_ar_ok     = (i_arburst == INCR) && (i_arsize == 3'd2) && (i_araddr[1:0] == 2'b00);
    assign w_ar_hs     = i_arvalid && r_arready;
    assign w_r_hs      = o_rvalid && i_rready;
    assign w_r_inrange = 32'(r_ridx) < MEM_DEPTH;

    assign o_arready = r_arready;
    assign o_rvalid  = (r_rs == RS_DATA);
    assign o_rlast   = o_rvalid && (r_rbeat == r_rlen);
    assign o_rdata   = w_r_inrange ? r_mem[r_ridx[IDX_W-1:0]] : '0;
    assign o_rresp   = (r_rerr || !w_r_inrange) ? SLVERR : OKAY;

    always_comb begin
        w_rs_nxt = r_rs;
        case (r_rs)
            RS_IDLE: if (w_ar_hs) w_rs_nxt = RS_DATA;
            RS_DATA: if (w_r_hs && o_rlast) w_rs_nxt = RS_IDLE;
            default: w_rs_nxt = RS_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rs      <= RS_IDLE;
            r_arready <= 1'b0;
            r_ridx    <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
            r_rerr    <= 1'b0;
        end else begin
            r_rs      <= w_rs_nxt;
            r_arready <= (r_rs == RS_IDLE) && i_arvalid && !r_arready;
            if (w_ar_hs) begin
                r_ridx  <= i_araddr[ADDR_W-1:2];
                r_rlen  <= i_arlen;
                r_rbeat <= '0;
                r_rerr  <= !w_ar_ok;
            end
            if (w_r_hs) begin
                r_ridx  <= r_ridx + WA_W'(1);
                r_rbeat <= r_rbeat + 8'd1;
            end
        end
    end

endmodule

// File: rtl/axi_sim_loop.sv
// Self-running AXI4 loop: traffic master writes then reads back a burst
// pattern through a counting passthrough monitor into the memory slave.
module axi_sim_loop
    import axi_sim_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned NUM_TXN   = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    output logic        done,
    output logic        pass,
    output logic [15:0] mismatch_cnt,
    output logic [15:0] wr_beats,
    output logic [15:0] rd_beats,
    output logic [15:0] resp_err_cnt,
    output logic        protocol_err
);

    localparam logic [7:0]  AXLEN    = 8'(BURST_LEN - 1);
    localparam logic [15:0] LAST_TXN = 16'(NUM_TXN - 1);

    logic                w_awvalid, w_awready, w_wvalid, w_wready, w_wlast;
    logic                w_bvalid, w_bready, w_arvalid, w_arready;
    logic                w_rvalid, w_rready, w_rlast;
    logic [ADDR_W-1:0]   w_awaddr, w_araddr;
    logic [7:0]          w_awlen, w_arlen;
    logic [2:0]          w_awsize, w_arsize;
    logic [1:0]          w_awburst, w_arburst, w_bresp, w_rresp;
    logic [DATA_W-1:0]   w_wdata, w_rdata;
    logic [DATA_W/8-1:0] w_wstrb;

    mst_state_t  r_state, w_state_nxt;
    logic        r_started;
    logic [15:0] r_txn;
    logic [7:0]  r_beat;
    logic [15:0] r_mismatch, r_resp_err, r_wr_beats, r_rd_beats;
    logic [7:0]  r_mon_awlen, r_mon_arlen, r_mon_wbeat, r_mon_rbeat;
    logic        r_proto_err;
    logic        w_aw_hs, w_ar_hs, w_w_hs, w_b_hs, w_r_hs, w_last_txn;

    assign w_aw_hs    = w_awvalid && w_awready;
    assign w_ar_hs    = w_arvalid && w_arready;
    assign w_w_hs     = w_wvalid && w_wready;
    assign w_b_hs     = w_bvalid && w_bready;
    assign w_r_hs     = w_rvalid && w_rready;
    assign w_last_txn = (r_txn == LAST_TXN);

    assign w_awaddr  = ADDR_W'(32'(r_txn) * BURST_LEN * 4);
    assign w_araddr  = w_awaddr;
    assign w_awlen   = AXLEN;
    assign w_arlen   = AXLEN;
    assign w_awsize  = 3'd2;
    assign w_arsize  = 3'd2;
    assign w_awburst = INCR;
    assign w_arburst = INCR;
    assign w_wstrb   = '1;
    assign w_wdata   = DATA_W'(exp_data(32'(r_txn), 32'(r_beat)));
    assign w_wlast   = (r_beat == AXLEN);

    always_comb begin
        w_state_nxt = r_state;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_arvalid   = 1'b0;
        w_bready    = (r_state != ST_IDLE);
        w_rready    = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  if (r_started) w_state_nxt = ST_WR_AW;
            ST_WR_AW: begin
                w_awvalid = 1'b1;
                if (w_awready) w_state_nxt = ST_WR_W;
            end
            ST_WR_W: begin
                w_wvalid = 1'b1;
                if (w_wready && w_wlast) w_state_nxt = ST_WR_B;
            end
            ST_WR_B:  if (w_bvalid) w_state_nxt = w_last_txn ? ST_RD_AR : ST_WR_AW;
            ST_RD_AR: begin
                w_arvalid = 1'b1;
                if (w_arready) w_state_nxt = ST_RD_R;
            end
            ST_RD_R:  if (w_rvalid && w_rlast) w_state_nxt = w_last_txn ? ST_DONE : ST_RD_AR;
            default:  w_state_nxt = r_state;
        endcase
    end

    // r_started delays leaving IDLE to the second edge after reset release
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_started  <= 1'b0;
            r_txn      <= '0;
            r_beat     <= '0;
            r_mismatch <= '0;
            r_resp_err <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) r_started <= 1'b1;
            if (w_w_hs) r_beat <= w_wlast ? '0 : r_beat + 8'd1;
            else if (w_r_hs) r_beat <= w_rlast ? '0 : r_beat + 8'd1;
            if (w_b_hs || (w_r_hs && w_rlast)) r_txn <= w_last_txn ? '0 : r_txn + 16'd1;
            if (w_r_hs && (w_rdata != DATA_W'(exp_data(32'(r_txn), 32'(r_beat)))))
                r_mismatch <= sat_inc(r_mismatch);
            if ((w_b_hs && w_bresp != OKAY) || (w_r_hs && w_rresp != OKAY))
                r_resp_err <= sat_inc(r_resp_err);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_beats  <= '0;
            r_rd_beats  <= '0;
            r_mon_awlen <= '0;
            r_mon_arlen <= '0;
            r_mon_wbeat <= '0;
            r_mon_rbeat <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_aw_hs) r_mon_awlen <= w_awlen;
            if (w_ar_hs) r_mon_arlen <= w_arlen;
            if (w_w_hs) begin
                r_wr_beats  <= sat_inc(r_wr_beats);
                r_mon_wbeat <= w_wlast ? '0 : r_mon_wbeat + 8'd1;
                if (w_wlast != (r_mon_wbeat == r_mon_awlen)) r_proto_err <= 1'b1;
            end
            if (w_r_hs) begin
                r_rd_beats  <= sat_inc(r_rd_beats);
                r_mon_rbeat <= w_rlast ? '0 : r_mon_rbeat + 8'd1;
                if (w_rlast != (r_mon_rbeat == r_mon_arlen)) r_proto_err <= 1'b1;
            end
        end
    end

    axi_sim_mem_slave #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_slave (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_awvalid (w_awvalid),
        .o_awready (w_awready),
        .i_awaddr  (w_awaddr),
        .i_awsize  (w_awsize),
        .i_awburst (w_awburst),
        .i_wvalid  (w_wvalid),
        .o_wready  (w_wready),
        .i_wdata   (w_wdata),
        .i_wstrb   (w_wstrb),
        .i_wlast   (w_wlast),
        .o_bvalid  (w_bvalid),
        .i_bready  (w_bready),
        .o_bresp   (w_bresp),
        .i_arvalid (w_arvalid),
        .o_arready (w_arready),
        .i_araddr  (w_araddr),
        .i_arlen   (w_arlen),
        .i_arsize  (w_arsize),
        .i_arburst (w_arburst),
        .o_rvalid  (w_rvalid),
        .i_rready  (w_rready),
        .o_rdata   (w_rdata),
        .o_rresp   (w_rresp),
        .o_rlast   (w_rlast)
    );

    assign done         = (r_state == ST_DONE);
    assign pass         = done && (r_mismatch == '0) && (r_resp_err == '0) && !r_proto_err;
    assign mismatch_cnt = r_mismatch;
    assign wr_beats     = r_wr_beats;
    assign rd_beats     = r_rd_beats;
    assign resp_err_cnt = r_resp_err;
    assign protocol_err = r_proto_err;

endmodule

// File: tb/tb_axi_sim_loop.sv
// Bench for axi_sim_loop: three configurations (default, shallow memory,
// single-beat bursts) checked against a burst-level model and a bus scoreboard.
module tb_axi_sim_loop;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rst_q = 1'b0;
    logic chk_en = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rstn;

    logic        done_v [3];
    logic        pass_v [3];
    logic        perr_v [3];
    logic [15:0] mism_v [3];
    logic [15:0] wr_v   [3];
    logic [15:0] rd_v   [3];
    logic [15:0] resp_v [3];

    axi_sim_loop u_def (
        .aclk(clk), .aresetn(rstn), .done(done_v[0]), .pass(pass_v[0]),
        .mismatch_cnt(mism_v[0]), .wr_beats(wr_v[0]), .rd_beats(rd_v[0]),
        .resp_err_cnt(resp_v[0]), .protocol_err(perr_v[0])
    );

    axi_sim_loop #(.MEM_DEPTH(16), .NUM_TXN(8)) u_oor (
        .aclk(clk), .aresetn(rstn), .done(done_v[1]), .pass(pass_v[1]),
        .mismatch_cnt(mism_v[1]), .wr_beats(wr_v[1]), .rd_beats(rd_v[1]),
        .resp_err_cnt(resp_v[1]), .protocol_err(perr_v[1])
    );

    axi_sim_loop #(.BURST_LEN(1), .NUM_TXN(4)) u_b1 (
        .aclk(clk), .aresetn(rstn), .done(done_v[2]), .pass(pass_v[2]),
        .mismatch_cnt(mism_v[2]), .wr_beats(wr_v[2]), .rd_beats(rd_v[2]),
        .resp_err_cnt(resp_v[2]), .protocol_err(perr_v[2])
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned exp_wr [3];
    int unsigned exp_rd [3];
    int unsigned exp_mism [3];
    int unsigned exp_resp [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", nm, act, req, $time);
        end
    endtask

    // Burst-level outcome: every beat whose word index lies beyond the memory
    // reads back 0 (a mismatch) with SLVERR; each such burst also gets a SLVERR BRESP.
    function automatic void model(input int unsigned depth, input int unsigned ntxn,
                                  input int unsigned blen, output int unsigned wr,
                                  output int unsigned rd, output int unsigned mism,
                                  output int unsigned resp);
        wr = ntxn * blen;
        rd = ntxn * blen;
        mism = 0;
        resp = 0;
        for (int unsigned i = 0; i < ntxn; i++) begin
            bit bad = 0;
            for (int unsigned b = 0; b < blen; b++) begin
                if (i * blen + b >= depth) begin
                    bad = 1;
                    mism++;
                    resp++;
                end
            end
            if (bad) resp++;
        end
    endfunction

    function automatic logic [31:0] pattern(input int unsigned word, input int unsigned blen);
        return 32'hA500_0000 | ((word / blen) << 8) | (word % blen);
    endfunction

    // Single compare process: output checks for all three DUTs plus a bus
    // scoreboard on the default instance.
    int unsigned sb_w = 0, sb_r = 0, sb_wb = 0, sb_rb = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 3; d++) begin
                    if (!rst_q) begin
                        chk($sformatf("rst_done[%0d]", d), 32'(done_v[d]), 0);
                        chk($sformatf("rst_pass[%0d]", d), 32'(pass_v[d]), 0);
                        chk($sformatf("rst_perr[%0d]", d), 32'(perr_v[d]), 0);
                        chk($sformatf("rst_mism[%0d]", d), 32'(mism_v[d]), 0);
                        chk($sformatf("rst_wr[%0d]", d), 32'(wr_v[d]), 0);
                        chk($sformatf("rst_rd[%0d]", d), 32'(rd_v[d]), 0);
                        chk($sformatf("rst_resp[%0d]", d), 32'(resp_v[d]), 0);
                    end else if (done_v[d]) begin
                        chk($sformatf("fin_wr[%0d]", d), 32'(wr_v[d]), exp_wr[d]);
                        chk($sformatf("fin_rd[%0d]", d), 32'(rd_v[d]), exp_rd[d]);
                        chk($sformatf("fin_mism[%0d]", d), 32'(mism_v[d]), exp_mism[d]);
                        chk($sformatf("fin_resp[%0d]", d), 32'(resp_v[d]), exp_resp[d]);
                        chk($sformatf("fin_perr[%0d]", d), 32'(perr_v[d]), 0);
                        chk($sformatf("fin_pass[%0d]", d), 32'(pass_v[d]),
                            32'(exp_mism[d] == 0 && exp_resp[d] == 0));
                    end else begin
                        chk($sformatf("run_perr[%0d]", d), 32'(perr_v[d]), 0);
                        chk($sformatf("run_wr_bound[%0d]", d), 32'(32'(wr_v[d]) <= exp_wr[d]), 1);
                        chk($sformatf("run_rd_bound[%0d]", d), 32'(32'(rd_v[d]) <= exp_rd[d]), 1);
                    end
                end
                if (!rst_q) begin
                    chk("rst_handshakes", 32'({u_def.w_awvalid, u_def.w_wvalid, u_def.w_bvalid,
                        u_def.w_arvalid, u_def.w_rvalid, u_def.w_bready, u_def.w_rready,
                        u_def.w_awready, u_def.w_wready, u_def.w_arready}), 0);
                    sb_wb = 0;
                    sb_rb = 0;
                end else begin
                    if (u_def.w_awvalid && u_def.w_awready) begin
                        sb_w = 32'(u_def.w_awaddr) >> 2;
                        sb_wb = 0;
                    end
                    if (u_def.w_wvalid && u_def.w_wready) begin
                        chk("sb_wdata", u_def.w_wdata, pattern(sb_w, 4));
                        chk("sb_wlast", 32'(u_def.w_wlast), 32'(sb_wb == 3));
                        sb_w++;
                        sb_wb++;
                    end
                    if (u_def.w_arvalid && u_def.w_arready) begin
                        sb_r = 32'(u_def.w_araddr) >> 2;
                        sb_rb = 0;
                    end
                    if (u_def.w_rvalid && u_def.w_rready) begin
                        chk("sb_rdata", u_def.w_rdata, pattern(sb_r, 4));
                        chk("sb_rresp", 32'(u_def.w_rresp), 0);
                        chk("sb_rlast", 32'(u_def.w_rlast), 32'(sb_rb == 3));
                        sb_r++;
                        sb_rb++;
                    end
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        int unsigned cyc = 0;
        while (!(done_v[0] && done_v[1] && done_v[2]) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_within_200"}, 32'(done_v[0] && done_v[1] && done_v[2]), 1);
    endtask

    task automatic lit(input int d, input string tag, input int unsigned wr, input int unsigned rd,
                       input int unsigned mism, input int unsigned resp, input logic p);
        chk($sformatf("%s_done[%0d]", tag, d), 32'(done_v[d]), 1);
        chk($sformatf("%s_wr[%0d]", tag, d), 32'(wr_v[d]), wr);
        chk($sformatf("%s_rd[%0d]", tag, d), 32'(rd_v[d]), rd);
        chk($sformatf("%s_mism[%0d]", tag, d), 32'(mism_v[d]), mism);
        chk($sformatf("%s_resp[%0d]", tag, d), 32'(resp_v[d]), resp);
        chk($sformatf("%s_pass[%0d]", tag, d), 32'(pass_v[d]), 32'(p));
        chk($sformatf("%s_perr[%0d]", tag, d), 32'(perr_v[d]), 0);
    endtask

    task automatic lit_all(input string tag);
        lit(0, tag, 32, 32, 0, 0, 1'b1);
        lit(1, tag, 32, 32, 16, 20, 1'b0);
        lit(2, tag, 4, 4, 0, 0, 1'b1);
    endtask

    initial begin
        int unsigned cyc;
        model(256, 8, 4, exp_wr[0], exp_rd[0], exp_mism[0], exp_resp[0]);
        model(16, 8, 4, exp_wr[1], exp_rd[1], exp_mism[1], exp_resp[1]);
        model(256, 4, 1, exp_wr[2], exp_rd[2], exp_mism[2], exp_resp[2]);

        @(posedge clk);
        chk_en = 1'b1;
        repeat (5) @(posedge clk);

        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("autostart_edge1_awvalid", 32'(u_def.w_awvalid), 0);
        @(posedge clk); #1;
        chk("autostart_edge2_awvalid", 32'(u_def.w_awvalid), 1);
        wait_done("run1");
        lit_all("run1");

        repeat (50) @(negedge clk);
        lit_all("hold50");

        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cyc = 0;
        while (wr_v[0] != 16'd13 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_txn3_wr_w", 32'(wr_v[0]), 13);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_done", 32'(done_v[0]), 0);
        chk("midrst_wr", 32'(wr_v[0]), 0);
        chk("midrst_awvalid", 32'(u_def.w_awvalid), 0);
        chk("midrst_wvalid", 32'(u_def.w_wvalid), 0);
        rstn = 1'b1;
        wait_done("rerun");
        lit_all("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
